doppler_fifo_reader: RTL and testbench
======================================

DOPPLER_FIFO_READER -- requirements
Module: doppler_fifo_reader

Interface
REQ-001 Parameter WIDTH, default 32: sample word width in bits.
REQ-002 Parameter DEEP, default 4: FIFO address bits; FIFO depth is 2^DEEP words.
REQ-003 Port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 Port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port start, input, 1 bit: one-cycle request to begin a burst; sampled only in IDLE.
REQ-006 Port burstLen, input, DEEP+1 bits: words per pass, latched at start.
REQ-007 Port replays, input, 4 bits: extra passes after the first, latched at start.
REQ-008 Port fifoQ, input, WIDTH bits: combinational FIFO read data.
REQ-009 Port outReady, input, 1 bit: downstream accepts outData when high with outValid.
REQ-010 Port readEnable, output, 1 bit: FIFO read-enable; high whenever the block is not in IDLE.
REQ-011 Port readNext, output, 1 bit: registered one-cycle pulse that advances the FIFO read pointer.
REQ-012 Port goToReg0, output, 1 bit: registered one-cycle pulse that rewinds the FIFO read pointer to 0.
REQ-013 Port outData, output, WIDTH bits: registered sample presented to downstream.
REQ-014 Port outValid, output, 1 bit: outData holds an undelivered sample.
REQ-015 Port busy, output, 1 bit: the block is not in IDLE.
REQ-016 Port done, output, 1 bit: one-cycle pulse when the final pass completes.
REQ-017 Port checksum, output, WIDTH bits: see Configuration.

Function
REQ-018 The state machine SHALL use the states IDLE, REWIND, SETTLE, CAPTURE, HOLD, STEP and FINISH.
REQ-019 In IDLE with start=1, the block SHALL latch burstLen (saturated to 2^DEEP) and replays, then enter REWIND.
REQ-020 In IDLE with start=1 and burstLen=0, the block SHALL go directly to FINISH with no strobes and no output words.
REQ-021 REWIND SHALL assert goToReg0 for exactly one cycle, then enter SETTLE.
REQ-022 SETTLE SHALL last one cycle, giving fifoQ time to settle after a pointer change, then enter CAPTURE.
REQ-023 CAPTURE SHALL register fifoQ into outData, set outValid, increment the word counter, and enter HOLD.
REQ-024 In HOLD, the handshake outValid&&outReady SHALL clear outValid in that same cycle; the state SHALL not advance without it.
REQ-025 After a handshake, if the word counter is below the pass length, the next state SHALL be STEP.
REQ-026 STEP SHALL pulse readNext for one cycle, then enter SETTLE.
REQ-027 After a handshake on the last word of a pass: with passes remaining, the next state SHALL be REWIND and the word counter SHALL clear; otherwise the next state SHALL be FINISH.
REQ-028 Each pass SHALL issue exactly burstLen-1 readNext pulses; no readNext SHALL follow the last word.
REQ-029 FINISH SHALL pulse done for one cycle, then return to IDLE.
REQ-030 Total words delivered SHALL equal burstLen×(replays+1).
REQ-031 readNext and goToReg0 SHALL never be high in the same cycle.
REQ-032 start asserted while busy=1 SHALL be ignored.
REQ-033 outData SHALL be stable while outValid=1 and outReady=0.

Reset
REQ-034 When reset_n is low, state SHALL be IDLE and all outputs and counters SHALL be 0, independent of clk.
REQ-035 Reset mid-burst SHALL drop outValid without completing a handshake and SHALL produce no done pulse.

Configuration
REQ-036 With FIFO_READER_CHECKSUM_EN defined, checksum SHALL be the modulo-2^WIDTH sum of all words handshaken since the last accepted start, cleared at start.
REQ-037 Without FIFO_READER_CHECKSUM_EN, checksum SHALL be tied to 0 and the adder SHALL not be synthesized.

Structure
REQ-038 The state enum and the default WIDTH/DEEP constants SHALL live in the shared package doppler_pkg.
REQ-039 A single sub-module, strobe_pulse (registered one-cycle pulse generator), SHALL drive both readNext and goToReg0.

Verification
REQ-040 Test 1 (single pass): burstLen=4, replays=0, FIFO holds 0x11..0x44, outReady=1 → 0x11,0x22,0x33,0x44 delivered; 1 goToReg0, 3 readNext, 1 done pulse.
REQ-041 Test 2 (replays): burstLen=3, replays=2 → 9 words, sequence 0x11,0x22,0x33 repeated 3 times; 3 goToReg0 pulses.
REQ-042 Test 3 (backpressure): outReady low for 5 cycles during word 2 → outData holds 0x22, no readNext pulses while stalled.
REQ-043 Test 4 (zero length): burstLen=0 → done one cycle after FINISH entry, no readNext/goToReg0, outValid never high.
REQ-044 Test 5 (saturation and busy start): burstLen=31 with DEEP=4 → exactly 16 words; start pulsed mid-burst → ignored.
REQ-045 Test 6 (reset): reset_n low during word 3 → all outputs 0 immediately, no done; checksum with FIFO_READER_CHECKSUM_EN for Test 1 = 0xAA.

Source files
------------

// File: rtl/doppler_pkg.sv
// Shared definitions for the Doppler FIFO reader.
// Contents: reader state enum and default WIDTH/DEEP constants.
package doppler_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEEP  = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REWIND  = 3'd1,
    SETTLE  = 3'd2,
    CAPTURE = 3'd3,
    HOLD    = 3'd4,
    STEP    = 3'd5,
    FINISH  = 3'd6
  } state_t;

endpackage

// File: rtl/doppler_fifo_reader_if.sv
// Output sample stream of the Doppler FIFO reader.
// Signals: outData (sample), outValid (sample pending), outReady (sink accepts).
// Modports: master = reader side, slave = downstream side.
interface doppler_fifo_reader_if #(
  parameter int WIDTH = doppler_pkg::DEF_WIDTH
);
  logic [WIDTH-1:0] outData;
  logic             outValid;
  logic             outReady;

  modport master (output outData, outValid, input  outReady);
  modport slave  (input  outData, outValid, output outReady);
endinterface

// File: rtl/strobe_pulse.sv
// Registered one-cycle pulse generator: pulse follows trig one clock later.
// Ports: clk, reset_n (async active-low), trig (combinational request), pulse.
module strobe_pulse (
  input  logic clk,
  input  logic reset_n,
  input  logic trig,
  output logic pulse
);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) pulse <= 1'b0;
    else          pulse <= trig;
endmodule

// File: rtl/doppler_fifo_reader.sv
// Doppler FIFO reader: replays a burst of burstLen words from an external
// FIFO (replays+1) times, one word per downstream handshake.
// Ports: clk, reset_n (async active-low); start/burstLen/replays (burst
// request, latched in IDLE); fifoQ (combinational FIFO data); out (stream
// master: outData/outValid/outReady); readEnable/readNext/goToReg0 (FIFO
// control); busy, done (status); checksum.
// Build option: FIFO_READER_CHECKSUM_EN enables the running checksum of
// delivered words; otherwise checksum is tied to 0.
module doppler_fifo_reader
  import doppler_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEEP  = DEF_DEEP
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [DEEP:0]        burstLen,
  input  logic [3:0]           replays,
  input  logic [WIDTH-1:0]     fifoQ,
  doppler_fifo_reader_if.master out,
  output logic                 readEnable,
  output logic                 readNext,
  output logic                 goToReg0,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     checksum
);

  localparam logic [DEEP:0] MAX_LEN = {1'b1, {DEEP{1'b0}}};
  localparam logic [DEEP:0] ONE     = 1;

  state_t           state;
  logic [DEEP:0]    len_q, wcnt;
  logic [3:0]       rep_q, pass_q;
  logic [WIDTH-1:0] data_q;
  logic             valid_q;

  logic go, hs, last_word, more_pass, rewind_trig, step_trig;

  assign go        = (state == IDLE) && start;
  assign hs        = (state == HOLD) && valid_q && out.outReady;
  // wcnt is already incremented in CAPTURE, so it equals words sent this pass
  assign last_word = (wcnt >= len_q);
  assign more_pass = (pass_q != rep_q);

  // Strobes fire in the cycle the FSM sits in REWIND / STEP
  assign rewind_trig = (go && (burstLen != '0)) || (hs && last_word && more_pass);
  assign step_trig   = hs && !last_word;

  strobe_pulse u_rewind (.clk(clk), .reset_n(reset_n), .trig(rewind_trig), .pulse(goToReg0));
  strobe_pulse u_step   (.clk(clk), .reset_n(reset_n), .trig(step_trig),   .pulse(readNext));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      len_q   <= '0;
      wcnt    <= '0;
      rep_q   <= '0;
      pass_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: if (start) begin
          len_q  <= (burstLen > MAX_LEN) ? MAX_LEN : burstLen;
          rep_q  <= replays;
          pass_q <= '0;
          wcnt   <= '0;
          state  <= (burstLen == '0) ? FINISH : REWIND;
        end
        REWIND:  state <= SETTLE;
        SETTLE:  state <= CAPTURE;   // fifoQ settles after a pointer move
        CAPTURE: begin
          data_q  <= fifoQ;
          valid_q <= 1'b1;
          wcnt    <= wcnt + ONE;
          state   <= HOLD;
        end
        HOLD: if (hs) begin
          valid_q <= 1'b0;
          if (!last_word) state <= STEP;
          else if (more_pass) begin
            state  <= REWIND;
            wcnt   <= '0;
            pass_q <= pass_q + 4'd1;
          end else state <= FINISH;
        end
        STEP:    state <= SETTLE;
        FINISH: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy         = (state != IDLE);
  assign readEnable   = busy;
  assign out.outData  = data_q;
  assign out.outValid = valid_q;

`ifdef FIFO_READER_CHECKSUM_EN
  logic [WIDTH-1:0] sum_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n)  sum_q <= '0;
    else if (go)   sum_q <= '0;
    else if (hs)   sum_q <= sum_q + data_q;
  assign checksum = sum_q;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_doppler_fifo_reader.sv
module tb_doppler_fifo_reader;
  localparam int WIDTH = 32;
  localparam int DEEP  = 4;

  logic clk = 1'b0, reset_n = 1'b0, start = 1'b0;
  logic [DEEP:0]      burstLen = '0;
  logic [3:0]         replays  = '0;
  logic [WIDTH-1:0]   fifoQ, checksum;
  logic readEnable, readNext, goToReg0, busy, done;

  doppler_fifo_reader_if #(.WIDTH(WIDTH)) o ();

  doppler_fifo_reader #(.WIDTH(WIDTH), .DEEP(DEEP)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .burstLen(burstLen),
    .replays(replays), .fifoQ(fifoQ), .out(o), .readEnable(readEnable),
    .readNext(readNext), .goToReg0(goToReg0), .busy(busy), .done(done),
    .checksum(checksum)
  );

  always #5 clk = ~clk;

  // FIFO model: 16 words 0x11, 0x22, ... ; pointer moved by the DUT strobes
  logic [WIDTH-1:0] mem [16];
  logic [3:0]       ptr;
  initial for (int i = 0; i < 16; i++) mem[i] = (i + 1) * 32'h11;
  always @(posedge clk or negedge reset_n)
    if (!reset_n)      ptr <= '0;
    else if (goToReg0) ptr <= '0;
    else if (readNext) ptr <= ptr + 4'd1;
  assign fifoQ = mem[ptr];

  int checks = 0, failures = 0;
  int cnt_rn = 0, cnt_g0 = 0, cnt_done = 0;
  bit saw_valid = 0;
  logic [WIDTH-1:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: counts strobes and scores every handshaken word
  always @(negedge clk) begin
    if (reset_n) begin
      if (readNext)   cnt_rn++;
      if (goToReg0)   cnt_g0++;
      if (done)       cnt_done++;
      if (o.outValid) saw_valid = 1;
      if (readNext && goToReg0) begin
        checks++; failures++;
        $display("FAIL strobe_overlap: readNext and goToReg0 both high");
      end
      if (o.outValid && o.outReady) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_word: got 0x%0h with empty scoreboard", o.outData);
        end else begin
          logic [WIDTH-1:0] e;
          e = exp_q.pop_front();
          if (o.outData !== e) begin
            failures++;
            $display("FAIL word: got 0x%0h expected 0x%0h", o.outData, e);
          end
        end
      end
    end
  end

  task automatic clear_counts();
    cnt_rn = 0; cnt_g0 = 0; cnt_done = 0; saw_valid = 0;
  endtask

  task automatic push_words(input int len, input int reps);
    for (int r = 0; r <= reps; r++)
      for (int i = 0; i < len; i++) exp_q.push_back(mem[i]);
  endtask

  task automatic start_burst(input int len, input int reps);
    @(posedge clk); #1;
    start = 1'b1; burstLen = len[DEEP:0]; replays = reps[3:0];
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, output int n);
    n = -1;
    for (int i = 1; i <= 600; i++) begin
      @(negedge clk);
      if (done) begin n = i; return; end
    end
    checks++; failures++;
    $display("FAIL %s_timeout: no done within 600 cycles", name);
  endtask

  int n, rn0;
  bit found;

  initial begin
    o.outReady = 1'b1;
    // Reset state
    #3;
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_valid", {31'd0, o.outValid}, 0);
    check("rst_strobes", {30'd0, readNext, goToReg0}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_data", o.outData, 0);
    check("rst_checksum", checksum, 0);
    @(posedge clk); #1 reset_n = 1'b1;

    // Test 1: single pass
    clear_counts();
    push_words(4, 0);
    start_burst(4, 0);
    wait_done("t1", n);
    repeat (2) @(negedge clk);
    check("t1_goToReg0", cnt_g0, 1);
    check("t1_readNext", cnt_rn, 3);
    check("t1_done", cnt_done, 1);
    check("t1_words_left", exp_q.size(), 0);
`ifdef FIFO_READER_CHECKSUM_EN
    check("t1_checksum", checksum, 32'hAA);
`else
    check("t1_checksum", checksum, 32'h0);
`endif

    // Test 2: replays
    clear_counts();
    push_words(3, 2);
    start_burst(3, 2);
    wait_done("t2", n);
    repeat (2) @(negedge clk);
    check("t2_goToReg0", cnt_g0, 3);
    check("t2_readNext", cnt_rn, 6);
    check("t2_words_left", exp_q.size(), 0);

    // Test 3: backpressure on word 2
    clear_counts();
    push_words(4, 0);
    start_burst(4, 0);
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk); #1;
      if (cnt_rn == 1) found = 1;
    end
    check("t3_first_step_seen", {31'd0, found}, 1);
    @(posedge clk); #1 o.outReady = 1'b0;
    rn0 = cnt_rn;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (o.outValid) found = 1;
    end
    check("t3_word2_valid", {31'd0, found}, 1);
    for (int i = 0; i < 5; i++) begin
      if (i != 0) @(negedge clk);
      check("t3_hold_data", o.outData, 32'h22);
      check("t3_hold_no_step", {31'd0, readNext}, 0);
    end
    #1 check("t3_stall_readNext", cnt_rn, rn0);
    @(posedge clk); #1 o.outReady = 1'b1;
    wait_done("t3", n);
    repeat (2) @(negedge clk);
    check("t3_readNext", cnt_rn, 3);
    check("t3_words_left", exp_q.size(), 0);

    // Test 4: zero length
    clear_counts();
    start_burst(0, 0);
    wait_done("t4", n);
    check("t4_done_latency", n, 2);
    repeat (2) @(negedge clk);
    check("t4_strobes", cnt_rn + cnt_g0, 0);
    check("t4_no_valid", {31'd0, saw_valid}, 0);
    check("t4_done", cnt_done, 1);

    // Test 5: saturation + start while busy
    clear_counts();
    push_words(16, 0);
    start_burst(31, 0);
    repeat (20) @(posedge clk);
    #1 start = 1'b1; burstLen = 5'd2;
    @(posedge clk); #1 start = 1'b0;
    wait_done("t5", n);
    repeat (3) @(negedge clk);
    check("t5_words_left", exp_q.size(), 0);
    check("t5_readNext", cnt_rn, 15);
    check("t5_goToReg0", cnt_g0, 1);
    check("t5_done", cnt_done, 1);
    check("t5_idle", {31'd0, busy}, 0);

    // Test 6: reset during word 3
    clear_counts();
    push_words(4, 0);
    start_burst(4, 0);
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk); #1;
      if (cnt_rn == 2) found = 1;
    end
    check("t6_second_step_seen", {31'd0, found}, 1);
    @(posedge clk); #1 o.outReady = 1'b0;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (o.outValid) found = 1;
    end
    check("t6_word3_data", o.outData, 32'h33);
    #1 reset_n = 1'b0;
    #1;
    check("t6_rst_valid", {31'd0, o.outValid}, 0);
    check("t6_rst_data", o.outData, 0);
    check("t6_rst_status", {28'd0, busy, readEnable, readNext, goToReg0}, 0);
    check("t6_rst_checksum", checksum, 0);
    check("t6_words_left", exp_q.size(), 2);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1; o.outReady = 1'b1;
    repeat (10) @(negedge clk);
    check("t6_no_done", cnt_done, 0);
    check("t6_idle", {31'd0, busy}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
